fpga_key_input: RTL and testbench



---
 rtl/fpga_io_pkg.sv | 25 ++
 rtl/fpga_key_input_key_debounce.sv | 126 ++++++++++++
 rtl/fpga_key_input.sv | 69 ++++++
 tb/tb_fpga_key_input.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_io_pkg.sv
// ============================================================================
// fpga_io_pkg : shared constants and key FSM encoding for the board-input path
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fpga_io_pkg;

    typedef logic [1:0] key_state_t;

    localparam key_state_t KEY_IDLE         = 2'd0;
    localparam key_state_t KEY_PRESS_WAIT   = 2'd1;
    localparam key_state_t KEY_HELD         = 2'd2;
    localparam key_state_t KEY_RELEASE_WAIT = 2'd3;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_LONG_CYCLES     = 100000000;
    localparam int DEF_CNT_W           = 27;

    localparam int NUM_KEYS = 4;
    localparam int NUM_SW   = 10;

endpackage

`default_nettype wire

// File: rtl/fpga_key_input_key_debounce.sv
// ============================================================================
// key_debounce : one pushbutton's synchronizer, debounce FSM and long-press timer
// Revision     : 1.0
// ============================================================================
`default_nettype none

module key_debounce
    import fpga_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_i,
    output logic press_o,
    output logic release_o,
    output logic held_o,
    output logic long_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             meta_q, sync_q;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, lcnt_q, lcnt_d;
    logic             flag_q, flag_d;
    logic             press_q, press_d, release_q, release_d;
    logic             held_q, held_d, long_q, long_d;
    logic             pressed;

    assign pressed = ~sync_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lcnt_d    = lcnt_q;
        flag_d    = flag_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            KEY_IDLE: begin
                if (pressed) begin
                    state_d = KEY_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            KEY_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = KEY_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = KEY_HELD;
                    press_d = 1'b1;
                    lcnt_d  = '0;
                    flag_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KEY_HELD: begin
                if (!pressed) begin
                    state_d = KEY_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (lcnt_q == LONG_LAST) begin
                    // Saturated: fire once per hold, then stay quiet
                    if (!flag_q) begin
                        long_d = 1'b1;
                        flag_d = 1'b1;
                    end
                end else begin
                    lcnt_d = lcnt_q + CNT_ONE;
                end
            end
            KEY_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = KEY_HELD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = KEY_IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = KEY_IDLE;
        endcase
        held_d = (state_d == KEY_HELD) || (state_d == KEY_RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
            state_q   <= KEY_IDLE;
            cnt_q     <= '0;
            lcnt_q    <= '0;
            flag_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            meta_q    <= key_i;
            sync_q    <= meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lcnt_q    <= lcnt_d;
            flag_q    <= flag_d;
            press_q   <= press_d;
            release_q <= release_d;
            held_q    <= held_d;
            long_q    <= long_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign held_o    = held_q;
    assign long_o    = long_q;

endmodule

`default_nettype wire

// File: rtl/fpga_key_input.sv
// ============================================================================
// fpga_key_input : synchronizes/debounces KEY and SW into single-cycle events
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fpga_key_input
    import fpga_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_SW-1:0]   SW,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] long_press,
    output logic [NUM_SW-1:0]   sw_sync,
    output logic [NUM_SW-1:0]   sw_change
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .CNT_W          (CNT_W)
        ) u_key (
            .clk      (clk),
            .resetn   (resetn),
            .key_i    (KEY[i]),
            .press_o  (key_press[i]),
            .release_o(key_release[i]),
            .held_o   (key_held[i]),
            .long_o   (long_press[i])
        );
    end

    logic [NUM_SW-1:0] sw_meta_q, sw_sync_q, sw_change_q, sw_change_d;
    logic [1:0]        prime_q;

    // Change detect is suppressed until the synchronizer has filled after reset
    assign sw_change_d = (prime_q == 2'd3) ? (sw_meta_q ^ sw_sync_q) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            sw_change_q <= '0;
            prime_q     <= 2'd0;
        end else begin
            sw_meta_q   <= SW;
            sw_sync_q   <= sw_meta_q;
            sw_change_q <= sw_change_d;
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign sw_sync   = sw_sync_q;
    assign sw_change = sw_change_q;

endmodule

`default_nettype wire

// File: tb/tb_fpga_key_input.sv
// ============================================================================
// tb_fpga_key_input : randomized scoreboard bench for fpga_key_input
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fpga_key_input;

    localparam int D = 4;
    localparam int L = 16;
    localparam int W = 5;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [3:0] key_press, key_release, key_held, long_press;
    logic [9:0] sw_sync, sw_change;

    fpga_key_input #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .KEY        (KEY),
        .SW         (SW),
        .key_press  (key_press),
        .key_release(key_release),
        .key_held   (key_held),
        .long_press (long_press),
        .sw_sync    (sw_sync),
        .sw_change  (sw_change)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] held;
        logic [3:0] lng;
        logic [9:0] sync;
        logic [9:0] chg;
    } exp_t;

    exp_t exp_q[$];
    exp_t e, a;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: sync is a two-sample delay; a key flips its debounced
    // level after D+1 consecutive opposite samples; long press after L held samples.
    logic [3:0] m_p1, m_p2;
    logic [9:0] m_s1;
    int         m_prime;
    bit         m_down[4];
    int         m_run[4];
    int         m_hc[4];
    bit         m_fired[4];
    exp_t       m_out;

    logic [3:0] prev_key;
    logic [9:0] prev_sw;
    logic       prev_rstn;

    function automatic void model_reset();
        m_p1 = 4'hF;
        m_p2 = 4'hF;
        m_s1 = '0;
        m_prime = 0;
        for (int i = 0; i < 4; i++) begin
            m_down[i] = 0; m_run[i] = 0; m_hc[i] = 0; m_fired[i] = 0;
        end
        m_out = '0;
    endfunction

    function automatic void model_edge(input logic [3:0] k, input logic [9:0] s);
        logic [3:0] seen;
        logic [9:0] new_sync;
        seen = m_p2;
        m_p2 = m_p1;
        m_p1 = k;
        m_out.press = '0;
        m_out.rel   = '0;
        m_out.lng   = '0;
        for (int i = 0; i < 4; i++) begin
            if (!m_down[i]) begin
                if (!seen[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_down[i] = 1; m_out.press[i] = 1'b1;
                        m_run[i] = 0; m_hc[i] = 0; m_fired[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else begin
                if (seen[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_down[i] = 0; m_out.rel[i] = 1'b1; m_run[i] = 0;
                    end
                end else begin
                    // A sample that cancels a pending release does not count toward the hold
                    if (m_run[i] == 0) begin
                        if (m_hc[i] < L) m_hc[i]++;
                        if (m_hc[i] == L && !m_fired[i]) begin
                            m_out.lng[i] = 1'b1; m_fired[i] = 1;
                        end
                    end
                    m_run[i] = 0;
                end
            end
            m_out.held[i] = m_down[i];
        end
        new_sync  = m_s1;
        m_out.chg = (m_prime >= 3) ? (new_sync ^ m_out.sync) : '0;
        m_out.sync = new_sync;
        m_s1 = s;
        if (m_prime < 3) m_prime++;
    endfunction

    task automatic cycle(input logic rn, input logic [3:0] k, input logic [9:0] s);
        @(posedge clk);
        #1;
        if (prev_rstn) model_edge(prev_key, prev_sw);
        resetn = rn;
        KEY    = k;
        SW     = s;
        if (!rn) model_reset();
        prev_rstn = rn;
        prev_key  = k;
        prev_sw   = s;
        exp_q.push_back(m_out);
    endtask

    task automatic repeat_cycle(input int n, input logic rn, input logic [3:0] k, input logic [9:0] s);
        for (int j = 0; j < n; j++) cycle(rn, k, s);
    endtask

    function automatic void cmp(input string name, input logic [9:0] act, input logic [9:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{press: key_press, rel: key_release, held: key_held,
                      lng: long_press, sync: sw_sync, chg: sw_change};
                vectors++;
                cmp("key_press",   {6'd0, a.press}, {6'd0, e.press});
                cmp("key_release", {6'd0, a.rel},   {6'd0, e.rel});
                cmp("key_held",    {6'd0, a.held},  {6'd0, e.held});
                cmp("long_press",  {6'd0, a.lng},   {6'd0, e.lng});
                cmp("sw_sync",     a.sync, e.sync);
                cmp("sw_change",   a.chg,  e.chg);
            end
        end
    end

    initial begin
        logic [3:0] k;
        logic [9:0] s;
        logic       rn;
        int         rem[4];
        int         idx;

        resetn = 1'b0;
        KEY    = 4'h0;
        SW     = 10'h3FF;
        model_reset();
        prev_rstn = 1'b0;
        prev_key  = 4'h0;
        prev_sw   = 10'h3FF;

        repeat_cycle(3, 1'b0, 4'h0, 10'h3FF);
        repeat_cycle(20, 1'b1, 4'hF, 10'h3FF);
        // Clean press on KEY[0]
        repeat_cycle(12, 1'b1, 4'hE, 10'h3FF);
        repeat_cycle(10, 1'b1, 4'hF, 10'h3FF);
        // Bounce on KEY[1]
        repeat_cycle(3, 1'b1, 4'hD, 10'h3FF);
        repeat_cycle(2, 1'b1, 4'hF, 10'h3FF);
        repeat_cycle(12, 1'b1, 4'hD, 10'h3FF);
        repeat_cycle(10, 1'b1, 4'hF, 10'h3FF);
        // Long press on KEY[2]
        repeat_cycle(40, 1'b1, 4'hB, 10'h3FF);
        repeat_cycle(10, 1'b1, 4'hF, 10'h3FF);
        // Release bounce on KEY[3]
        repeat_cycle(10, 1'b1, 4'h7, 10'h3FF);
        repeat_cycle(2, 1'b1, 4'hF, 10'h3FF);
        repeat_cycle(5, 1'b1, 4'h7, 10'h3FF);
        repeat_cycle(10, 1'b1, 4'hF, 10'h3FF);
        // Simultaneous press with a switch toggle, then reset mid-hold
        repeat_cycle(12, 1'b1, 4'hC, 10'h3DF);
        repeat_cycle(2, 1'b0, 4'hC, 10'h3DF);
        repeat_cycle(15, 1'b1, 4'hF, 10'h3DF);

        k = 4'hF;
        s = 10'h3DF;
        for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 8);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0) begin
                    k[i] = ~k[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 45)
                                                          : $urandom_range(1, 8);
                end else begin
                    rem[i]--;
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                idx = $urandom_range(0, 9);
                s[idx] = ~s[idx];
            end
            rn = ($urandom_range(0, 599) != 0);
            cycle(rn, k, s);
        end

        @(negedge clk);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
